bram_fifo_ctrl: RTL and testbench

//  Sequencer that sits directly upstream of the single-port bram and turns it into a FIFO.

---
 rtl/bram_fifo_ctrl.sv | 94 +++++++++
 tb/tb_bram_fifo_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo_ctrl.sv
// rtl/bram_fifo_ctrl.sv - FIFO sequencer in front of a single-port bram with 1-cycle registered read
module bram_fifo_ctrl #(
    parameter int RAM_WIDTH     = 8,
    parameter int RAM_ADDR_BITS = 11
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [RAM_WIDTH-1:0]     in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RAM_WIDTH-1:0]     out_data,
    output logic [RAM_ADDR_BITS:0]   level,
    output logic                     ram_enable,
    output logic                     write_enable,
    output logic [RAM_ADDR_BITS-1:0] address,
    output logic [RAM_WIDTH-1:0]     ram_wdata,
    input  logic [RAM_WIDTH-1:0]     ram_rdata
);
    localparam logic [RAM_ADDR_BITS:0]   DEPTH   = {1'b1, {RAM_ADDR_BITS{1'b0}}};
    localparam logic [RAM_ADDR_BITS:0]   LVL_ONE = (RAM_ADDR_BITS+1)'(1);
    localparam logic [RAM_ADDR_BITS-1:0] PTR_ONE = RAM_ADDR_BITS'(1);

    logic [RAM_ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [RAM_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [RAM_ADDR_BITS:0]   level_q, level_d;
    logic                     rd_pend_q, rd_pend_d;
    logic                     out_valid_q, out_valid_d;
    logic [RAM_WIDTH-1:0]     out_data_q, out_data_d;

    logic slot_free;
    logic rd_issue;
    logic wr_fire;

    // A read is only issued when the output register is guaranteed free by the time its data lands.
    assign slot_free = !out_valid_q || out_ready;
    assign rd_issue  = (level_q != '0) && !rd_pend_q && slot_free;
    assign in_ready  = (level_q != DEPTH) && !rd_issue;
    assign wr_fire   = in_valid && in_ready;

    assign ram_enable   = rd_issue || wr_fire;
    assign write_enable = wr_fire;
    assign address      = rd_issue ? rd_ptr_q : (wr_fire ? wr_ptr_q : '0);
    assign ram_wdata    = wr_fire ? in_data : '0;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign level     = level_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        rd_pend_d   = rd_pend_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        if (rd_issue) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            level_d   = level_q - LVL_ONE;
            rd_pend_d = 1'b1;
        end else if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            level_d  = level_q + LVL_ONE;
        end

        if (rd_pend_q) begin
            out_data_d  = ram_rdata;
            out_valid_d = 1'b1;
            rd_pend_d   = 1'b0;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            rd_pend_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            rd_pend_q   <= rd_pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb/tb_bram_fifo_ctrl.sv - directed and randomized-backpressure bench for bram_fifo_ctrl
module tb_bram_fifo_ctrl;
    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [11:0] level;
    logic        ram_enable;
    logic        write_enable;
    logic [10:0] address;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    logic [7:0]  mem [0:2047];
    logic [7:0]  exp_q [$];
    int          checks;
    int          errors;
    int          waddr;

    bram_fifo_ctrl #(.RAM_WIDTH(8), .RAM_ADDR_BITS(11)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .ram_enable(ram_enable), .write_enable(write_enable),
        .address(address), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clock = ~clock;

    // Single-port bram with registered read data
    always @(posedge clock) begin
        if (ram_enable) begin
            if (write_enable) mem[address] <= ram_wdata;
            else ram_rdata <= mem[address];
        end
    end

    task automatic step(input logic iv, input logic [7:0] d, input logic ordy,
                        output logic acc, output logic got);
        @(negedge clock);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        acc = in_valid & in_ready;
        got = out_valid & out_ready;
    endtask

    task automatic test_reset();
        logic acc, got;
        @(negedge clock); #1;
        checks++;
        if (level !== 12'd0 || out_valid !== 1'b0 || out_data !== 8'h00 || ram_enable !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state level=%0d ov=%b od=%h en=%b ir=%b exp 0 0 00 0 1", level, out_valid, out_data, ram_enable, in_ready);
        end
        reset = 1'b1;
        step(1'b1, 8'h11, 1'b0, acc, got);
        checks++;
        if (acc !== 1'b1 || write_enable !== 1'b1 || address !== 11'd0) begin
            errors++; $display("FAIL rst_w0 acc=%b we=%b addr=%0d exp 1 1 0", acc, write_enable, address);
        end
        step(1'b1, 8'h22, 1'b0, acc, got);
        checks++;
        if (acc !== 1'b0 || ram_enable !== 1'b1 || write_enable !== 1'b0 || address !== 11'd0) begin
            errors++; $display("FAIL rst_rd0 acc=%b en=%b we=%b addr=%0d exp 0 1 0 0", acc, ram_enable, write_enable, address);
        end
        step(1'b1, 8'h22, 1'b0, acc, got);
        checks++;
        if (acc !== 1'b1 || address !== 11'd1) begin
            errors++; $display("FAIL rst_w1 acc=%b addr=%0d exp 1 1", acc, address);
        end
        step(1'b1, 8'h33, 1'b0, acc, got);
        checks++;
        if (acc !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h11 || address !== 11'd2) begin
            errors++; $display("FAIL rst_w2 acc=%b ov=%b od=%h addr=%0d exp 1 1 11 2", acc, out_valid, out_data, address);
        end
        step(1'b0, 8'h00, 1'b1, acc, got);
        checks++;
        if (got !== 1'b1 || ram_enable !== 1'b1 || write_enable !== 1'b0 || address !== 11'd1) begin
            errors++; $display("FAIL rst_rd1 got=%b en=%b we=%b addr=%0d exp 1 1 0 1", got, ram_enable, write_enable, address);
        end
        step(1'b0, 8'h00, 1'b0, acc, got);
        checks++;
        if (level !== 12'd1 || out_data !== 8'h11) begin
            errors++; $display("FAIL rst_pre level=%0d od=%h exp 1 11", level, out_data);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if (level !== 12'd0 || out_valid !== 1'b0 || out_data !== 8'h00 || ram_enable !== 1'b0) begin
            errors++; $display("FAIL rst_async level=%0d ov=%b od=%h en=%b exp 0 0 00 0", level, out_valid, out_data, ram_enable);
        end
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || level !== 12'd0) begin
            errors++; $display("FAIL rst_release ir=%b level=%0d exp 1 0", in_ready, level);
        end
        step(1'b0, 8'h00, 1'b0, acc, got);
        checks++;
        if (out_valid !== 1'b0 || level !== 12'd0) begin
            errors++; $display("FAIL rst_discard ov=%b level=%0d exp 0 0", out_valid, level);
        end
    endtask

    task automatic test_single();
        logic acc, got;
        step(1'b1, 8'hA5, 1'b1, acc, got);
        checks++;
        if (acc !== 1'b1 || ram_enable !== 1'b1 || write_enable !== 1'b1 || address !== 11'd0 || ram_wdata !== 8'hA5) begin
            errors++; $display("FAIL single_wr acc=%b en=%b we=%b addr=%0d wd=%h exp 1 1 1 0 a5", acc, ram_enable, write_enable, address, ram_wdata);
        end
        step(1'b0, 8'h00, 1'b1, acc, got);
        checks++;
        if (ram_enable !== 1'b1 || write_enable !== 1'b0 || address !== 11'd0 || level !== 12'd1) begin
            errors++; $display("FAIL single_rd en=%b we=%b addr=%0d level=%0d exp 1 0 0 1", ram_enable, write_enable, address, level);
        end
        step(1'b0, 8'h00, 1'b1, acc, got);
        checks++;
        if (out_valid !== 1'b0 || ram_enable !== 1'b0 || address !== 11'd0 || ram_wdata !== 8'h00 || level !== 12'd0) begin
            errors++; $display("FAIL single_idle ov=%b en=%b addr=%0d wd=%h level=%0d exp 0 0 0 00 0", out_valid, ram_enable, address, ram_wdata, level);
        end
        step(1'b0, 8'h00, 1'b1, acc, got);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
            errors++; $display("FAIL single_out ov=%b od=%h exp 1 a5", out_valid, out_data);
        end
        step(1'b0, 8'h00, 1'b1, acc, got);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_drop ov=%b exp 0", out_valid);
        end
        waddr = 1;
    endtask

    task automatic test_fill_drain(input int words, input int base, input int exp_level);
        logic acc, got;
        logic [7:0] exp_d;
        int n, cyc, v;
        n = 0;
        cyc = 0;
        while (n < words && cyc < 5000) begin
            v = base + n;
            step(1'b1, v[7:0], 1'b0, acc, got);
            if (acc) begin
                checks++;
                if (address !== waddr[10:0]) begin
                    errors++; $display("FAIL fill_addr got=%0d exp=%0d", address, waddr);
                end
                exp_q.push_back(v[7:0]);
                waddr = (waddr + 1) % 2048;
                n++;
            end
            cyc++;
        end
        checks++;
        if (n != words) begin
            errors++; $display("FAIL fill_count got=%0d exp=%0d", n, words);
        end
        step(1'b0, 8'h00, 1'b0, acc, got);
        checks++;
        if (level !== exp_level[11:0] || out_valid !== 1'b1 || out_data !== exp_q[0]) begin
            errors++; $display("FAIL fill_level level=%0d ov=%b od=%h exp %0d 1 %h", level, out_valid, out_data, exp_level, exp_q[0]);
        end
        if (exp_level == 2048) begin
            for (int k = 0; k < 5; k++) begin
                step(1'b1, 8'hEE, 1'b0, acc, got);
                checks++;
                if (acc !== 1'b0 || in_ready !== 1'b0 || ram_enable !== 1'b0) begin
                    errors++; $display("FAIL full_stall acc=%b ir=%b en=%b exp 0 0 0", acc, in_ready, ram_enable);
                end
            end
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 10000) begin
            step(1'b0, 8'h00, 1'b1, acc, got);
            if (got) begin
                exp_d = exp_q.pop_front();
                checks++;
                if (out_data !== exp_d) begin
                    errors++; $display("FAIL drain_data got=%h exp=%h", out_data, exp_d);
                end
            end
            cyc++;
        end
        step(1'b0, 8'h00, 1'b1, acc, got);
        checks++;
        if (exp_q.size() != 0 || level !== 12'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL drain_end left=%0d level=%0d ov=%b exp 0 0 0", exp_q.size(), level, out_valid);
        end
    endtask

    task automatic test_contention();
        logic acc, got;
        logic [7:0] exp_d;
        int n, cyc, v;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            v = 8'h40 + n;
            step(1'b1, v[7:0], 1'b1, acc, got);
            checks++;
            if (in_ready !== ((c % 2) == 0) || (!in_ready && (ram_enable !== 1'b1 || write_enable !== 1'b0))) begin
                errors++; $display("FAIL contend_cycle c=%0d ir=%b en=%b we=%b exp ir=%b", c, in_ready, ram_enable, write_enable, (c % 2) == 0);
            end
            if (got) begin
                exp_d = exp_q.pop_front();
                checks++;
                if (out_data !== exp_d) begin
                    errors++; $display("FAIL contend_data got=%h exp=%h", out_data, exp_d);
                end
            end
            if (acc) begin
                exp_q.push_back(v[7:0]);
                n++;
            end
        end
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 100) begin
            step(1'b0, 8'h00, 1'b1, acc, got);
            if (got) begin
                exp_d = exp_q.pop_front();
                checks++;
                if (out_data !== exp_d) begin
                    errors++; $display("FAIL contend_data got=%h exp=%h", out_data, exp_d);
                end
            end
            cyc++;
        end
        checks++;
        if (exp_q.size() != 0 || n != 10) begin
            errors++; $display("FAIL contend_end left=%0d accepted=%0d exp 0 10", exp_q.size(), n);
        end
    endtask

    task automatic test_backpressure();
        logic acc, got, iv, ordy, prev_stall;
        logic [7:0] cur, prev_data, exp_d;
        int n, cyc;
        n = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_data = 8'h00;
        cur = 8'($urandom);
        while ((n < 10000 || exp_q.size() > 0) && cyc < 60000) begin
            iv   = (n < 10000) && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            step(iv, cur, ordy, acc, got);
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    errors++; $display("FAIL bp_stable ov=%b od=%h exp 1 %h", out_valid, out_data, prev_data);
                end
            end
            if (got) begin
                exp_d = exp_q.pop_front();
                checks++;
                if (out_data !== exp_d) begin
                    errors++; $display("FAIL bp_data got=%h exp=%h", out_data, exp_d);
                end
            end
            if (acc) begin
                exp_q.push_back(cur);
                cur = 8'($urandom);
                n++;
            end
            prev_stall = out_valid & !out_ready;
            prev_data  = out_data;
            cyc++;
        end
        step(1'b0, 8'h00, 1'b1, acc, got);
        checks++;
        if (n != 10000 || exp_q.size() != 0 || level !== 12'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_end sent=%0d left=%0d level=%0d ov=%b exp 10000 0 0 0", n, exp_q.size(), level, out_valid);
        end
    endtask

    initial begin
        clock = 1'b0;
        reset = 1'b0;
        in_valid = 1'b0;
        in_data = 8'h00;
        out_ready = 1'b0;
        checks = 0;
        errors = 0;
        waddr = 0;
        test_reset();
        test_single();
        test_fill_drain(2049, 0, 2048);
        test_fill_drain(10, 8'hC0, 9);
        test_contention();
        test_backpressure();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
